// File: rtl/gpu_ucode_sequencer.sv
// Microcode sequencer: walks a GPU opcode's microroutine, one microword per cycle,
// handling WAIT_* stalls and the repeat counter for REPEAT_UCODE / CONTINUE_OR_END.
package gpu_ucode_pkg;
    typedef enum logic [5:0] {
        ENDMICRO        = 6'd0,
        VRAM_to_MAU     = 6'd1,
        INC_PC_A        = 6'd2,
        CPY_A_to_B      = 6'd3,
        DRAW_PIXEL      = 6'd4,
        REPEAT_UCODE    = 6'd5,
        CONTINUE_OR_END = 6'd6,
        WAIT_CYCLE      = 6'd7,
        WAIT_ALL_MAU    = 6'd8,
        WAIT_ANY_MAU    = 6'd9,
        WAIT_FB         = 6'd10,
        WAIT_LDU        = 6'd11,
        WAIT_DTCU       = 6'd12,
        WAIT_START      = 6'd13
    } GPU_Microcode_enum;
endpackage

module gpu_ucode_sequencer
    import gpu_ucode_pkg::*;
#(
    parameter int UADDR_W = 8,
    parameter int REP_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [UADDR_W-1:0]   instr_entry,
    input  logic [REP_W-1:0]     instr_rep,
    output logic [UADDR_W-1:0]   rom_addr,
    input  GPU_Microcode_enum    rom_data,
    output GPU_Microcode_enum    current_microcode,
    input  logic                 mau_any_busy,
    input  logic                 mau_all_busy,
    input  logic                 fb_busy,
    input  logic                 ldu_busy,
    input  logic                 dtcu_busy,
    input  logic                 start_go,
    output logic                 stalled,
    output logic [REP_W-1:0]     rep_remaining,
    output logic                 routine_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state;
    logic [UADDR_W-1:0] pc;
    logic [UADDR_W-1:0] entry_reg;
    logic [REP_W-1:0]   rep_cnt;
    logic [REP_W-1:0]   rep_dec;
    logic               rep_more;

    assign instr_ready       = (state == S_IDLE);
    assign rom_addr          = pc;
    assign current_microcode = (state == S_RUN) ? rom_data : ENDMICRO;
    assign rep_remaining     = rep_cnt;
    assign rep_more          = (rep_cnt > REP_W'(1));
    // Counter saturates at 0 once the last pass is consumed.
    assign rep_dec           = rep_more ? rep_cnt - REP_W'(1) : '0;

    always_comb begin
        stalled = 1'b0;
        if (state == S_RUN) begin
            case (rom_data)
                WAIT_ALL_MAU: stalled = mau_any_busy;
                WAIT_ANY_MAU: stalled = mau_all_busy;
                WAIT_FB:      stalled = fb_busy;
                WAIT_LDU:     stalled = ldu_busy;
                WAIT_DTCU:    stalled = dtcu_busy;
                WAIT_START:   stalled = !start_go;
                default:      stalled = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            entry_reg    <= '0;
            rep_cnt      <= '0;
            routine_done <= 1'b0;
        end else begin
            routine_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state     <= S_RUN;
                        pc        <= instr_entry;
                        entry_reg <= instr_entry;
                        rep_cnt   <= (instr_rep == '0) ? REP_W'(1) : instr_rep;
                    end
                end
                default: begin
                    if (!stalled) begin
                        case (rom_data)
                            ENDMICRO: begin
                                state        <= S_IDLE;
                                routine_done <= 1'b1;
                            end
                            REPEAT_UCODE: begin
                                rep_cnt <= rep_dec;
                                pc      <= rep_more ? entry_reg : pc + UADDR_W'(1);
                            end
                            CONTINUE_OR_END: begin
                                rep_cnt <= rep_dec;
                                if (rep_more) begin
                                    pc <= pc + UADDR_W'(1);
                                end else begin
                                    state        <= S_IDLE;
                                    routine_done <= 1'b1;
                                end
                            end
                            default: pc <= pc + UADDR_W'(1);
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Directed bench for gpu_ucode_sequencer: ROM model in the bench, checks sampled on negedge.
module tb_gpu_ucode_sequencer;
    import gpu_ucode_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_entry;
    logic [15:0]       instr_rep;
    logic [7:0]        rom_addr;
    GPU_Microcode_enum rom_data;
    GPU_Microcode_enum current_microcode;
    logic              mau_any_busy, mau_all_busy, fb_busy, ldu_busy, dtcu_busy, start_go;
    logic              stalled;
    logic [15:0]       rep_remaining;
    logic              routine_done;

    GPU_Microcode_enum rom [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    gpu_ucode_sequencer #(.UADDR_W(8), .REP_W(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_entry(instr_entry), .instr_rep(instr_rep),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .current_microcode(current_microcode),
        .mau_any_busy(mau_any_busy), .mau_all_busy(mau_all_busy),
        .fb_busy(fb_busy), .ldu_busy(ldu_busy), .dtcu_busy(dtcu_busy),
        .start_go(start_go), .stalled(stalled),
        .rep_remaining(rep_remaining), .routine_done(routine_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer an instruction while idle; returns in cycle T+1 (first microword executing).
    task automatic launch(input logic [7:0] entry, input logic [15:0] rep);
        chk("launch_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_entry = entry;
        instr_rep   = rep;
        step();
        instr_valid = 1'b0;
    endtask

    // Check one executing word (and repeat count) then advance a cycle.
    task automatic word(input string tag, input GPU_Microcode_enum w, input logic [15:0] rep);
        chk({tag, "_word"}, 32'(current_microcode), 32'(w));
        chk({tag, "_rep"}, 32'(rep_remaining), 32'(rep));
        chk({tag, "_ready"}, 32'(instr_ready), 32'd0);
        step();
    endtask

    task automatic done_cycle(input string tag);
        chk({tag, "_done"}, 32'(routine_done), 32'd1);
        chk({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_idle_word"}, 32'(current_microcode), 32'(ENDMICRO));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = ENDMICRO;
        rom[8'h10] = VRAM_to_MAU;  rom[8'h11] = INC_PC_A;        rom[8'h12] = ENDMICRO;
        rom[8'h20] = CPY_A_to_B;   rom[8'h21] = REPEAT_UCODE;    rom[8'h22] = ENDMICRO;
        rom[8'h30] = DRAW_PIXEL;   rom[8'h31] = CONTINUE_OR_END; rom[8'h32] = INC_PC_A;
        rom[8'h40] = WAIT_ANY_MAU; rom[8'h41] = WAIT_ALL_MAU;    rom[8'h42] = WAIT_START;
        rom[8'h50] = WAIT_FB;
        rom[8'hFF] = INC_PC_A;

        rst = 1'b1; instr_valid = 1'b0; instr_entry = '0; instr_rep = '0;
        mau_any_busy = 0; mau_all_busy = 0; fb_busy = 0; ldu_busy = 0; dtcu_busy = 0; start_go = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_word", 32'(current_microcode), 32'(ENDMICRO));
        chk("rst_rep", 32'(rep_remaining), 32'd0);
        chk("rst_done", 32'(routine_done), 32'd0);
        chk("rst_stall", 32'(stalled), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);

        // Simple 3-word routine, then back-to-back accept in the done cycle
        launch(8'h10, 16'd1);
        word("r1a", VRAM_to_MAU, 16'd1);
        word("r1b", INC_PC_A, 16'd1);
        word("r1c", ENDMICRO, 16'd1);
        done_cycle("r1");

        // REPEAT_UCODE x3: 7 RUN cycles
        launch(8'h20, 16'd3);
        word("rp0", CPY_A_to_B, 16'd3);
        word("rp1", REPEAT_UCODE, 16'd3);
        word("rp2", CPY_A_to_B, 16'd2);
        word("rp3", REPEAT_UCODE, 16'd2);
        word("rp4", CPY_A_to_B, 16'd1);
        word("rp5", REPEAT_UCODE, 16'd1);
        word("rp6", ENDMICRO, 16'd0);
        done_cycle("rp");
        step();
        chk("rp_done_clear", 32'(routine_done), 32'd0);

        // rep=0 behaves as rep=1
        launch(8'h20, 16'd0);
        word("z0", CPY_A_to_B, 16'd1);
        word("z1", REPEAT_UCODE, 16'd1);
        word("z2", ENDMICRO, 16'd0);
        done_cycle("z");

        // CONTINUE_OR_END rep=2 falls through to 0x33
        launch(8'h30, 16'd2);
        word("c0", DRAW_PIXEL, 16'd2);
        word("c1", CONTINUE_OR_END, 16'd2);
        word("c2", INC_PC_A, 16'd1);
        chk("c3_addr", 32'(rom_addr), 32'h33);
        word("c3", ENDMICRO, 16'd1);
        done_cycle("c");

        // CONTINUE_OR_END rep=1 ends immediately
        launch(8'h30, 16'd1);
        word("d0", DRAW_PIXEL, 16'd1);
        word("d1", CONTINUE_OR_END, 16'd1);
        done_cycle("d");
        chk("d_rep_zero", 32'(rep_remaining), 32'd0);
        step();

        // WAIT stalls
        mau_all_busy = 1'b1; mau_any_busy = 1'b1;
        launch(8'h40, 16'd1);
        for (int i = 0; i < 5; i++) begin
            chk("wany_stall", 32'(stalled), 32'd1);
            chk("wany_addr", 32'(rom_addr), 32'h40);
            chk("wany_word", 32'(current_microcode), 32'(WAIT_ANY_MAU));
            step();
        end
        mau_all_busy = 1'b0; mau_any_busy = 1'b0;
        #1;
        chk("wany_release", 32'(stalled), 32'd0);
        step();
        chk("wall_addr", 32'(rom_addr), 32'h41);
        chk("wall_stall", 32'(stalled), 32'd0);
        step();
        chk("wst_addr", 32'(rom_addr), 32'h42);
        chk("wst_stall0", 32'(stalled), 32'd1);
        step();
        chk("wst_stall1", 32'(stalled), 32'd1);
        chk("wst_hold", 32'(rom_addr), 32'h42);
        start_go = 1'b1;
        #1;
        chk("wst_release", 32'(stalled), 32'd0);
        step();
        start_go = 1'b0;
        word("wend", ENDMICRO, 16'd1);
        done_cycle("w");
        step();

        // Reset while stalled mid-routine
        fb_busy = 1'b1;
        launch(8'h50, 16'd4);
        chk("rs_stall", 32'(stalled), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fb_busy = 1'b0;
        chk("rs_word", 32'(current_microcode), 32'(ENDMICRO));
        chk("rs_rep", 32'(rep_remaining), 32'd0);
        chk("rs_done", 32'(routine_done), 32'd0);
        chk("rs_ready", 32'(instr_ready), 32'd1);
        chk("rs_stall_clr", 32'(stalled), 32'd0);
        step();
        chk("rs_done2", 32'(routine_done), 32'd0);

        // PC wrap 0xFF -> 0x00; instr_valid during RUN ignored
        launch(8'hFF, 16'd1);
        chk("wr_addr_ff", 32'(rom_addr), 32'hFF);
        instr_valid = 1'b1; instr_entry = 8'h10; instr_rep = 16'd9;
        word("wr0", INC_PC_A, 16'd1);
        instr_valid = 1'b0;
        chk("wr_addr_00", 32'(rom_addr), 32'h00);
        word("wr1", ENDMICRO, 16'd1);
        done_cycle("wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end
endmodule

// File: doc/gpu_ucode_sequencer.md
Name: gpu_ucode_sequencer

Overview:
- Steps the GPU through the microroutine of each accepted GPU opcode.
- Drives the microcode ROM address and presents one microword per cycle as current_microcode to the GPU microcode decoder.
- Owns the WAIT_* halting conditions and the repeat counter behind REPEAT_UCODE and CONTINUE_OR_END.
- Sits between the GPU instruction front-end (opcode → routine entry address, repeat amount) and the decoder.

Parameters:
- UADDR_W, 8, microcode ROM address width.
- REP_W, 16, repeat-amount width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- instr_valid, in, 1, new opcode routine offered.
- instr_ready, out, 1, sequencer idle and accepting.
- instr_entry, in, UADDR_W, ROM address of the routine's first microword.
- instr_rep, in, REP_W, repeat amount (0 treated as 1).
- rom_addr, out, UADDR_W, microcode ROM address (asynchronous-read ROM).
- rom_data, in, GPU_Microcode_enum, microword at rom_addr, same cycle.
- current_microcode, out, GPU_Microcode_enum, microword executed this cycle (to decoder).
- mau_any_busy, in, 1, at least one MAU busy.
- mau_all_busy, in, 1, every MAU busy.
- fb_busy, ldu_busy, dtcu_busy, in, 1 each, unit busy.
- start_go, in, 1, CPU start strobe/level.
- stalled, out, 1, current microword is a WAIT_* whose condition is unmet.
- rep_remaining, out, REP_W, current repeat count.
- routine_done, out, 1, one-cycle pulse when a routine finishes.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. State IDLE; pc=0; rep_cnt=0; entry_reg=0; routine_done=0. rst mid-routine aborts immediately, with no done pulse.
- States: IDLE and RUN.
- Outputs in IDLE:
  - instr_ready=1.
  - current_microcode=ENDMICRO, so the decoder produces no strobes.
  - rom_addr=pc.
  - stalled=0.
- Accept: instr_valid && instr_ready at cycle T. At T+1: state=RUN, pc=entry_reg=instr_entry, rep_cnt=max(instr_rep,1). The first microword executes at T+1.
- RUN:
  - rom_addr=pc; current_microcode=rom_data; instr_ready=0.
  - Exactly one microword executes per cycle unless stalled.
- Stall conditions (hold pc, re-present the same word):
  - WAIT_ALL_MAU: while mau_any_busy.
  - WAIT_ANY_MAU: while mau_all_busy.
  - WAIT_FB: while fb_busy.
  - WAIT_LDU: while ldu_busy.
  - WAIT_DTCU: while dtcu_busy.
  - WAIT_START: while !start_go.
  - stalled is combinational from the current word and the busy inputs. A WAIT whose condition is already met costs exactly 1 cycle.
  - While stalled, current_microcode still carries the WAIT word; the decoder emits only hlt_* for it.
- Next-pc rules, when not stalled:
  - ENDMICRO: → IDLE; routine_done=1 next cycle.
  - REPEAT_UCODE, rep_cnt>1: rep_cnt−1, pc=entry_reg (routine restarts).
  - REPEAT_UCODE, rep_cnt≤1: rep_cnt=0, pc+1.
  - CONTINUE_OR_END, rep_cnt>1: rep_cnt−1, pc+1.
  - CONTINUE_OR_END, rep_cnt≤1: rep_cnt=0, → IDLE, routine_done pulse.
  - All other words, including WAIT_CYCLE: pc+1.
- pc increment is modulo 2^UADDR_W; wrap from all-ones to 0 is legal and not flagged.
- rep_cnt never underflows; it saturates at 0.
- routine_done is registered: high for the single cycle following the terminating word, while state is already IDLE.
- A new instruction may be accepted in that same cycle. Back-to-back routines therefore have a 1-cycle IDLE gap.
- instr_valid while RUN is ignored (ready=0), with no side effects.
- The decoder's decr_rep_amount strobe is informational; the counter is owned here.

Test Plan:
- Reset, then a routine at entry 0x10 = [VRAM_to_MAU, INC_PC_A, ENDMICRO], rep=1 → current_microcode sequence VRAM_to_MAU, INC_PC_A, ENDMICRO at cycles T+1..T+3; routine_done at T+4; instr_ready high at T+4.
- Entry 0x20 = [CPY_A_to_B, REPEAT_UCODE, ENDMICRO], rep=3 → CPY_A_to_B executes 3 times; rep_remaining 3→2→1→0; ENDMICRO reached after the 3rd REPEAT; total 7 RUN cycles.
- Same routine with rep=0 → identical to rep=1: one CPY, one REPEAT, ENDMICRO.
- Entry 0x30 = [DRAW_PIXEL, CONTINUE_OR_END, INC_PC_A], rep=2 → DRAW_PIXEL, CONTINUE_OR_END (rep 2→1), INC_PC_A, then ROM word 0x33. With 0x33 = ENDMICRO, done after 4 words. With rep=1, done right after CONTINUE_OR_END and INC_PC_A is never presented.
- WAIT_ANY_MAU with mau_all_busy=1 for 5 cycles → stalled=1 and pc held for 5 cycles; advances the cycle mau_all_busy drops. WAIT_ALL_MAU with mau_any_busy=0 → 1 cycle, no stall. WAIT_START holds until start_go pulses.
- rst asserted while stalled mid-routine → next cycle IDLE, current_microcode=ENDMICRO, rep_remaining=0, no routine_done. Routine entry at address 0xFF with word 0xFF = INC_PC_A → next word fetched from 0x00.
